// File: rtl/async_fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the async FIFO write-port arbiter.
// Optional burst-lock mode is enabled with ARB_BURST_LOCK_EN.
package async_fifo_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

   localparam int MAXREQ = 16;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Returns {any, idx}: first set req after ptr, wrapping modulo n.
   function automatic logic [4:0] rr_next(
      input logic [MAXREQ-1:0] req,
      input logic [3:0]        ptr,
      input int                n
   );
      logic [4:0] r;
      int k;
      r = '0;
      for (int s = n; s >= 1; s--) begin
         k = (int'(ptr) + s) % n;
         if (req[k[3:0]]) r = {1'b1, k[3:0]};
      end
      return r;
   endfunction

endpackage

// File: rtl/async_fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write-port arbiter.
// Feature macro ARB_BURST_LOCK_EN does not affect this bundle.
interface async_fifo_wr_arbiter_if
   import async_fifo_arb_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DWIDTH = 8
);
   logic [NREQ-1:0]        req;
   logic [NREQ*DWIDTH-1:0] req_data;
   logic [NREQ-1:0]        gnt;
   logic                   full;
   logic                   push;
   logic [DWIDTH-1:0]      wdata;
   logic [idx_w(NREQ)-1:0] owner;

   modport master (
      input  req, req_data, full,
      output gnt, push, wdata, owner
   );

   modport slave (
      output req, req_data, full,
      input  gnt, push, wdata, owner
   );
endinterface

// File: rtl/async_fifo_wr_arbiter_rr_priority_picker.sv
// Rotating-priority one-hot encoder; search starts at ptr+1.
// Independent of ARB_BURST_LOCK_EN.
module rr_priority_picker
   import async_fifo_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDXW = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [NREQ-1:0] onehot,
   output logic [IDXW-1:0] idx,
   output logic            any
);
   logic [4:0] res;

   always_comb begin
      res    = rr_next(MAXREQ'(req), 4'(ptr), NREQ);
      any    = res[4];
      idx    = IDXW'(res[3:0]);
      onehot = any ? (NREQ'(1) << idx) : '0;
   end
endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter for the async FIFO write port, one output register.
// Define ARB_BURST_LOCK_EN to keep a grant for up to BURST words.
module async_fifo_wr_arbiter
   import async_fifo_arb_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DWIDTH = 8,
   parameter int BURST  = 4
) (
   input logic                      wclk,
   input logic                      reset_L,
   async_fifo_wr_arbiter_if.master  bus
);
   localparam int IDXW = idx_w(NREQ);

   if (BURST < 1 || NREQ < 2 || NREQ > MAXREQ) begin : g_param_chk
      $error("async_fifo_wr_arbiter: bad parameter");
   end

   logic              valid_q;
   logic [DWIDTH-1:0] data_q;
   logic [IDXW-1:0]   owner_q;
   logic [IDXW-1:0]   rr_ptr;
   logic [IDXW-1:0]   rr_ptr_d;
   logic [IDXW-1:0]   pick_ptr;
   logic [IDXW-1:0]   pick_idx;
   logic [IDXW-1:0]   acc_idx;
   logic [NREQ-1:0]   pick_onehot;
   logic              pick_any;
   logic              slot_free;
   logic              gnt_en;
   logic              accept;
   logic              lock_hold;

   rr_priority_picker #(.NREQ(NREQ)) u_pick (
      .req    (bus.req),
      .ptr    (pick_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign slot_free = ~valid_q | ~bus.full;
   assign gnt_en    = reset_L & slot_free;
   assign accept    = gnt_en & (lock_hold | pick_any);
   assign bus.push  = valid_q & ~bus.full;
   assign bus.wdata = data_q;
   assign bus.owner = owner_q;

   always_comb begin
      bus.gnt = '0;
      acc_idx = lock_hold ? owner_q : pick_idx;
      if (gnt_en) begin
         bus.gnt = lock_hold ? (NREQ'(1) << owner_q) : pick_onehot;
      end
   end

`ifdef ARB_BURST_LOCK_EN
   localparam int BW = $clog2(BURST + 1);

   arb_state_e      state;
   arb_state_e      state_d;
   logic [BW-1:0]   burst_cnt;
   logic [BW-1:0]   burst_cnt_d;

   assign lock_hold = (state == ARB_LOCK) && bus.req[owner_q]
                      && (burst_cnt < BW'(BURST));
   // When a lock ends, the next search already starts after the old owner.
   assign pick_ptr  = (state == ARB_LOCK) ? owner_q : rr_ptr;

   always_ff @(posedge wclk or negedge reset_L) begin
      if (!reset_L) begin
         state     <= ARB_IDLE;
         burst_cnt <= '0;
      end else begin
         state     <= state_d;
         burst_cnt <= burst_cnt_d;
      end
   end

   always_comb begin
      state_d     = state;
      burst_cnt_d = burst_cnt;
      rr_ptr_d    = rr_ptr;
      if (state == ARB_LOCK && !lock_hold) begin
         state_d  = ARB_IDLE;
         rr_ptr_d = owner_q;
      end
      if (accept) begin
         state_d     = ARB_LOCK;
         burst_cnt_d = lock_hold ? burst_cnt + 1'b1 : BW'(1);
      end
   end
`else
   assign lock_hold = 1'b0;
   assign pick_ptr  = rr_ptr;

   always_comb begin
      rr_ptr_d = rr_ptr;
      if (accept) rr_ptr_d = acc_idx;
   end
`endif

   always_ff @(posedge wclk or negedge reset_L) begin
      if (!reset_L) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         owner_q <= '0;
         rr_ptr  <= IDXW'(NREQ - 1);
      end else begin
         rr_ptr <= rr_ptr_d;
         if (accept) begin
            valid_q <= 1'b1;
            data_q  <= bus.req_data[acc_idx*DWIDTH +: DWIDTH];
            owner_q <= acc_idx;
         end else if (bus.push) begin
            valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed-vector and scoreboard bench for async_fifo_wr_arbiter.
// Expected tables follow the ARB_BURST_LOCK_EN setting of the build.
module tb_async_fifo_wr_arbiter;

   logic wclk = 1'b0;
   logic reset_L = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 wclk = ~wclk;

   async_fifo_wr_arbiter_if #(.NREQ(4), .DWIDTH(8)) bus ();

   async_fifo_wr_arbiter #(.NREQ(4), .DWIDTH(8), .BURST(4)) dut (
      .wclk    (wclk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   typedef struct {
      logic [3:0] req;
      logic       full;
      logic [3:0] gnt;
      logic       push;
      logic [7:0] wdata;
      logic [1:0] owner;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input logic [3:0] r, input logic f);
      @(negedge wclk);
      bus.req  = r;
      bus.full = f;
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] seq [4];
      logic [5:0] exp_seq [4];
      logic       pend [4];
      int         words;
      int         cyc;

      bus.req      = 4'b1111;
      bus.full     = 1'b0;
      bus.req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

`ifdef ARB_BURST_LOCK_EN
      tbl.push_back('{4'b0011, 1'b0, 4'b0001, 1'b0, 8'h00, 2'd0});
      tbl.push_back('{4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0});
      tbl.push_back('{4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0});
      tbl.push_back('{4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0});
      tbl.push_back('{4'b0011, 1'b0, 4'b0010, 1'b1, 8'hA0, 2'd0});
      tbl.push_back('{4'b0011, 1'b0, 4'b0010, 1'b1, 8'hB1, 2'd1});
      tbl.push_back('{4'b0011, 1'b0, 4'b0010, 1'b1, 8'hB1, 2'd1});
      tbl.push_back('{4'b0011, 1'b0, 4'b0010, 1'b1, 8'hB1, 2'd1});
      tbl.push_back('{4'b0011, 1'b0, 4'b0001, 1'b1, 8'hB1, 2'd1});
      tbl.push_back('{4'b0010, 1'b0, 4'b0010, 1'b1, 8'hA0, 2'd0});
      tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hB1, 2'd1});
      tbl.push_back('{4'b1111, 1'b0, 4'b0100, 1'b0, 8'hB1, 2'd1});
`else
      tbl.push_back('{4'b1111, 1'b0, 4'b0001, 1'b0, 8'h00, 2'd0});
      tbl.push_back('{4'b1111, 1'b0, 4'b0010, 1'b1, 8'hA0, 2'd0});
      tbl.push_back('{4'b1111, 1'b0, 4'b0100, 1'b1, 8'hB1, 2'd1});
      tbl.push_back('{4'b1111, 1'b0, 4'b1000, 1'b1, 8'hC2, 2'd2});
      tbl.push_back('{4'b1111, 1'b0, 4'b0001, 1'b1, 8'hD3, 2'd3});
      tbl.push_back('{4'b1010, 1'b0, 4'b0010, 1'b1, 8'hA0, 2'd0});
      tbl.push_back('{4'b1010, 1'b0, 4'b1000, 1'b1, 8'hB1, 2'd1});
      tbl.push_back('{4'b1010, 1'b0, 4'b0010, 1'b1, 8'hD3, 2'd3});
      tbl.push_back('{4'b1010, 1'b1, 4'b0000, 1'b0, 8'hB1, 2'd1});
      tbl.push_back('{4'b1010, 1'b1, 4'b0000, 1'b0, 8'hB1, 2'd1});
      tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hB1, 2'd1});
      tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 8'hB1, 2'd1});
      tbl.push_back('{4'b0100, 1'b1, 4'b0100, 1'b0, 8'hB1, 2'd1});
      tbl.push_back('{4'b0100, 1'b1, 4'b0000, 1'b0, 8'hC2, 2'd2});
      tbl.push_back('{4'b0001, 1'b0, 4'b0001, 1'b1, 8'hC2, 2'd2});
      tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0});
`endif

      // Reset state with all requesters asserting
      #12;
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_push", 32'(bus.push), 0);
      chk("rst_wdata", 32'(bus.wdata), 0);
      chk("rst_owner", 32'(bus.owner), 0);
      @(negedge wclk);
      reset_L = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         if (i == 0) begin
            bus.req  = tbl[i].req;
            bus.full = tbl[i].full;
            #1;
         end else begin
            apply(tbl[i].req, tbl[i].full);
         end
         chk($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
         chk($sformatf("vec%0d_push", i), 32'(bus.push), 32'(tbl[i].push));
         chk($sformatf("vec%0d_wdata", i), 32'(bus.wdata), 32'(tbl[i].wdata));
         chk($sformatf("vec%0d_owner", i), 32'(bus.owner), 32'(tbl[i].owner));
      end

      // Stall: word B1 held for 5 full cycles, then pushed exactly once
      apply(4'b0010, 1'b0);
      chk("stall_accept", 32'(bus.gnt), 32'b0010);
      for (int k = 0; k < 5; k++) begin
         apply(4'b1111, 1'b1);
         chk($sformatf("stall%0d_push", k), 32'(bus.push), 0);
         chk($sformatf("stall%0d_gnt", k), 32'(bus.gnt), 0);
         chk($sformatf("stall%0d_wdata", k), 32'(bus.wdata), 32'hB1);
      end
      apply(4'b0000, 1'b0);
      chk("unstall_push", 32'(bus.push), 1);
      chk("unstall_wdata", 32'(bus.wdata), 32'hB1);
      apply(4'b0000, 1'b0);
      chk("unstall_once", 32'(bus.push), 0);

      // Reset with a pending word: nothing pushed, requester 0 first after
      apply(4'b1000, 1'b0);
      chk("prerst_gnt", 32'(bus.gnt), 32'b1000);
      apply(4'b0000, 1'b1);
      chk("prerst_hold", 32'(bus.wdata), 32'hD3);
      #2;
      bus.req  = 4'b1111;
      bus.full = 1'b0;
      reset_L  = 1'b0;
      #1;
      chk("midrst_push", 32'(bus.push), 0);
      chk("midrst_gnt", 32'(bus.gnt), 0);
      @(negedge wclk);
      reset_L = 1'b1;
      #1;
      chk("postrst_gnt", 32'(bus.gnt), 32'b0001);
      chk("postrst_wdata", 32'(bus.wdata), 0);
      apply(4'b0000, 1'b0);
      chk("postrst_push", 32'(bus.push), 1);
      chk("postrst_word", 32'(bus.wdata), 32'hA0);
      apply(4'b0000, 1'b0);

      // Scoreboard: random req/full, per-requester ordering and counts
      for (int i = 0; i < 4; i++) begin
         seq[i] = '0;
         exp_seq[i] = '0;
         pend[i] = 1'b0;
      end
      words = 0;
      cyc = 0;
      while (words < 400 && cyc < 4000) begin
         @(negedge wclk);
         for (int i = 0; i < 4; i++) begin
            if (!pend[i]) pend[i] = ($urandom_range(0, 99) < 60);
            bus.req[i] = pend[i];
            bus.req_data[i*8 +: 8] = {2'(i), seq[i]};
         end
         bus.full = ($urandom_range(0, 99) < 30);
         #1;
         chk("rnd_onehot", 32'($onehot0(bus.gnt)), 1);
         chk("rnd_gnt_req", 32'(bus.gnt & ~bus.req), 0);
         if (bus.push) begin
            chk($sformatf("rnd_order_r%0d", bus.wdata[7:6]),
                32'(bus.wdata[5:0]), 32'(exp_seq[bus.wdata[7:6]]));
            exp_seq[bus.wdata[7:6]] = bus.wdata[5:0] + 6'd1;
            words++;
         end
         for (int i = 0; i < 4; i++) begin
            if (bus.req[i] && bus.gnt[i]) begin
               pend[i] = 1'b0;
               seq[i] = seq[i] + 6'd1;
            end
         end
         cyc++;
      end
      chk("rnd_budget", 32'(words >= 400), 1);
      for (int k = 0; k < 3; k++) begin
         apply(4'b0000, 1'b0);
         if (bus.push) begin
            chk("drain_order", 32'(bus.wdata[5:0]),
                32'(exp_seq[bus.wdata[7:6]]));
            exp_seq[bus.wdata[7:6]] = bus.wdata[5:0] + 6'd1;
         end
      end
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rnd_count_r%0d", i), 32'(exp_seq[i]), 32'(seq[i]));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
